// File: rtl/ad_pkg.sv
// Shared definitions for the AD7276 serial read controller:
// FSM encodings, frame geometry and the frame-to-sample unpack helper.
package ad_pkg;

    localparam int AD_FRAME_BITS = 16;
    localparam int AD_DATA_BITS  = 12;
    localparam int AD_LEAD_ZEROS = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_QUIET = 3'd4;

    typedef struct packed {
        logic                    err;
        logic [AD_DATA_BITS-1:0] data;
    } ad_smp_t;

    function automatic ad_smp_t ad_unpack(
        input logic [AD_FRAME_BITS-1:0] frm
    );
        ad_smp_t s;
        s.err  = |frm[AD_FRAME_BITS-1 -: AD_LEAD_ZEROS];
        s.data = frm[AD_FRAME_BITS-AD_LEAD_ZEROS-1 -: AD_DATA_BITS];
        return s;
    endfunction

endpackage

// File: rtl/ad_sclk_gen.sv
// Serial clock generator: half-period divider plus bit counter,
// producing sclk, a capture strobe and an end-of-frame strobe.
module ad_sclk_gen
    import ad_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic setup_i,
    input  logic shift_i,
    output logic sclk_o,
    output logic half_o,
    output logic cap_o,
    output logic done_o
);

    localparam int BW = $clog2(AD_FRAME_BITS);
    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(AD_FRAME_BITS - 1);

    logic [7:0]    div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          sclk_q, sclk_d;
    logic          active;
    logic          last;

    assign active = setup_i | shift_i;
    assign last   = (bit_q == BIT_LAST);
    assign half_o = active && (div_q == DIV_LAST);
    assign cap_o  = shift_i && half_o && sclk_q;
    assign done_o = cap_o && last;
    assign sclk_o = sclk_q;

    always_comb begin
        div_d = '0;
        if (active && !half_o) div_d = div_q + 8'd1;

        bit_d = bit_q;
        if (!shift_i) bit_d = '0;
        else if (cap_o) bit_d = bit_q + 1'b1;

        // sclk stays high after the last rising edge so the frame ends idle-high
        sclk_d = sclk_q;
        if (!active) sclk_d = 1'b1;
        else if (half_o) begin
            if (setup_i) sclk_d = 1'b0;
            else sclk_d = !sclk_q || last;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q  <= '0;
            bit_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            div_q  <= div_d;
            bit_q  <= bit_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/ad7276_rd.sv
// AD7276 serial read controller: trigger handling, frame FSM,
// sample extraction and output registers for one ADC channel.
module ad7276_rd
    import ad_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int QUIET_CYC = 4,
    parameter int SMP_DIV   = 100
) (
    input  logic                    mclk0,
    input  logic                    hrst_n,
    input  logic                    cfg_en,
    input  logic                    cfg_auto,
    input  logic                    trig,
    output logic                    ad_cs_n,
    output logic                    ad_sclk,
    input  logic                    ad_sdata,
    output logic [AD_DATA_BITS-1:0] dat,
    output logic                    dat_vld,
    output logic                    dat_err,
    output logic                    trig_miss,
    output logic                    busy,
    output logic [15:0]             smp_cnt
);

    localparam logic [7:0]  Q_LAST = 8'(QUIET_CYC - 1);
    localparam logic [15:0] T_LAST = 16'(SMP_DIV - 1);

    logic [2:0]               state_q, state_d;
    logic [7:0]               qcnt_q, qcnt_d;
    logic [15:0]              tick_q, tick_d;
    logic                     sdata_q;
    logic [AD_FRAME_BITS-2:0] shift_q, shift_d;
    logic [AD_DATA_BITS-1:0]  dat_q, dat_d;
    logic                     err_q, err_d;
    logic                     vld_q;
    logic [15:0]              smp_cnt_q, smp_cnt_d;
    logic                     cs_n_q, cs_n_d;
    logic                     busy_d1_q;

    logic                     sclk, half, cap, fdone;
    logic                     tick, req, acc;
    logic [AD_FRAME_BITS-1:0] frame;
    ad_smp_t                  smp;

    ad_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk (
        .clk_i  (mclk0),
        .rst_n_i(hrst_n),
        .setup_i(state_q == ST_SETUP),
        .shift_i(state_q == ST_SHIFT),
        .sclk_o (sclk),
        .half_o (half),
        .cap_o  (cap),
        .done_o (fdone)
    );

    // a trigger in the cycle busy falls still counts as a miss
    assign tick      = cfg_en && (tick_q == T_LAST);
    assign req       = cfg_en && (cfg_auto ? tick : trig);
    assign busy      = (state_q != ST_IDLE);
    assign acc       = req && !busy && !busy_d1_q;
    assign trig_miss = req && !acc;

    assign frame = {shift_q, sdata_q};
    assign smp   = ad_unpack(frame);

    always_comb begin
        state_d = state_q;
        qcnt_d  = '0;
        unique case (state_q)
            ST_IDLE:  if (acc) state_d = ST_SETUP;
            ST_SETUP: if (half) state_d = ST_SHIFT;
            ST_SHIFT: if (fdone) state_d = ST_DONE;
            ST_DONE:  state_d = ST_QUIET;
            ST_QUIET: begin
                qcnt_d = qcnt_q + 8'd1;
                if (qcnt_q == Q_LAST) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tick_d = '0;
        if (cfg_en && !tick) tick_d = tick_q + 16'd1;
        shift_d   = cap ? frame[AD_FRAME_BITS-2:0] : shift_q;
        dat_d     = fdone ? smp.data : dat_q;
        err_d     = fdone ? smp.err : err_q;
        smp_cnt_d = fdone ? smp_cnt_q + 16'd1 : smp_cnt_q;
        cs_n_d    = !(state_d == ST_SETUP || state_d == ST_SHIFT);
    end

    always_ff @(posedge mclk0 or negedge hrst_n) begin
        if (!hrst_n) begin
            state_q   <= ST_IDLE;
            qcnt_q    <= '0;
            tick_q    <= '0;
            sdata_q   <= 1'b0;
            shift_q   <= '0;
            dat_q     <= '0;
            err_q     <= 1'b0;
            vld_q     <= 1'b0;
            smp_cnt_q <= '0;
            cs_n_q    <= 1'b1;
            busy_d1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            tick_q    <= tick_d;
            sdata_q   <= ad_sdata;
            shift_q   <= shift_d;
            dat_q     <= dat_d;
            err_q     <= err_d;
            vld_q     <= fdone;
            smp_cnt_q <= smp_cnt_d;
            cs_n_q    <= cs_n_d;
            busy_d1_q <= busy;
        end
    end

    assign ad_cs_n = cs_n_q;
    assign ad_sclk = sclk;
    assign dat     = dat_q;
    assign dat_err = err_q;
    assign dat_vld = vld_q;
    assign smp_cnt = smp_cnt_q;

endmodule
